// File: rtl/cpu_trace_buffer.sv
// CPU trace capture FIFO with first-word-fall-through read, optional flow-change filter and wrap mode.
// Define TRACE_TIMESTAMP_EN to add a 16-bit free-running timestamp stored with each entry.
module cpu_trace_buffer #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WRAP   = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     filter,
    input  logic                     clear,
    input  logic [ADDR_W-1:0]        pc,
    input  logic [31:0]              instr,
    input  logic [3:0]               flags,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [ADDR_W-1:0]        rd_pc,
    output logic [31:0]              rd_instr,
    output logic [3:0]               rd_flags,
    output logic [15:0]              rd_time,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic             push, pop, full, wr_en;

    logic [ADDR_W-1:0] mem_pc_q    [DEPTH];
    logic [31:0]       mem_instr_q [DEPTH];
    logic [3:0]        mem_flags_q [DEPTH];

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] ts_q, ts_d;
    logic [15:0] mem_time_q [DEPTH];
`endif

    always_comb begin
        push       = enable & (~filter | flags[3] | flags[2]);
        pop        = rd_valid & rd_ready;
        full       = (count_q == FULL_CNT);
        wr_en      = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && full && !pop) begin
                // Full with no room freed: wrap mode retires the oldest entry in place of the new one.
                overflow_d = 1'b1;
                if (WRAP != 0) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
            end else if (push) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (wr_en && !pop && !full) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !wr_en) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_pc_q[wr_ptr_q]    <= pc;
            mem_instr_q[wr_ptr_q] <= instr;
            mem_flags_q[wr_ptr_q] <= flags;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    always_comb begin
        ts_d = ts_q + 16'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_time_q[wr_ptr_q] <= ts_q;
        end
    end

    assign rd_time = rd_valid ? mem_time_q[rd_ptr_q] : '0;
`else
    assign rd_time = '0;
`endif

    assign rd_valid = (count_q != '0);
    assign rd_pc    = rd_valid ? mem_pc_q[rd_ptr_q]    : '0;
    assign rd_instr = rd_valid ? mem_instr_q[rd_ptr_q] : '0;
    assign rd_flags = rd_valid ? mem_flags_q[rd_ptr_q] : '0;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: a stop-on-full and a wrap instance share stimulus,
// each checked against its own queue scoreboard.
module tb_cpu_trace_buffer;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [3:0]  flags;
        logic [15:0] tm;
    } entry_t;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        filter;
    logic        clear;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  flags;
    logic        rd_ready;

    logic        rdv  [2];
    logic [31:0] rpc  [2];
    logic [31:0] rins [2];
    logic [3:0]  rfl  [2];
    logic [15:0] rtm  [2];
    logic [2:0]  cnt  [2];
    logic        ovfo [2];

    entry_t      sb  [2][$];
    logic        ovf [2];
    logic [15:0] ts;
    int          total;
    int          bad;

    cpu_trace_buffer #(.ADDR_W(32), .DEPTH(4), .WRAP(0)) dut_stop (
        .clock(clock), .reset(reset), .enable(enable), .filter(filter), .clear(clear),
        .pc(pc), .instr(instr), .flags(flags),
        .rd_valid(rdv[0]), .rd_ready(rd_ready),
        .rd_pc(rpc[0]), .rd_instr(rins[0]), .rd_flags(rfl[0]), .rd_time(rtm[0]),
        .count(cnt[0]), .overflow(ovfo[0])
    );

    cpu_trace_buffer #(.ADDR_W(32), .DEPTH(4), .WRAP(1)) dut_wrap (
        .clock(clock), .reset(reset), .enable(enable), .filter(filter), .clear(clear),
        .pc(pc), .instr(instr), .flags(flags),
        .rd_valid(rdv[1]), .rd_ready(rd_ready),
        .rd_pc(rpc[1]), .rd_instr(rins[1]), .rd_flags(rfl[1]), .rd_time(rtm[1]),
        .count(cnt[1]), .overflow(ovfo[1])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input int w, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, w, obs, exp);
        end
    endtask

    task automatic check_all();
        entry_t head;
        int     n;
        for (int w = 0; w < 2; w++) begin
            n = sb[w].size();
            if (n != 0) head = sb[w][0];
            else head = '{32'h0, 32'h0, 4'h0, 16'h0};
            chk("rd_valid", w, 64'(rdv[w]), 64'(n != 0));
            chk("count", w, 64'(cnt[w]), 64'(n));
            chk("overflow", w, 64'(ovfo[w]), 64'(ovf[w]));
            chk("rd_pc", w, 64'(rpc[w]), 64'(head.pc));
            chk("rd_instr", w, 64'(rins[w]), 64'(head.instr));
            chk("rd_flags", w, 64'(rfl[w]), 64'(head.flags));
`ifdef TRACE_TIMESTAMP_EN
            chk("rd_time", w, 64'(rtm[w]), 64'(head.tm));
`else
            chk("rd_time", w, 64'(rtm[w]), 64'(0));
`endif
        end
    endtask

    task automatic model_edge(input logic en, input logic filt, input logic clr,
                              input logic [31:0] p, input logic [31:0] i,
                              input logic [3:0] f, input logic rdy);
        entry_t e;
        logic   psh, pp, full;
        e = '{p, i, f, ts};
        psh = en & (~filt | f[3] | f[2]);
        for (int w = 0; w < 2; w++) begin
            if (clr) begin
                sb[w].delete();
                ovf[w] = 1'b0;
            end else begin
                pp   = (sb[w].size() != 0) && rdy;
                full = (sb[w].size() == 4);
                if (pp) void'(sb[w].pop_front());
                if (psh) begin
                    if (full && !pp) begin
                        ovf[w] = 1'b1;
                        if (w == 1) begin
                            void'(sb[w].pop_front());
                            sb[w].push_back(e);
                        end
                    end else begin
                        sb[w].push_back(e);
                    end
                end
            end
        end
        ts = ts + 16'd1;
    endtask

    // Entered and left at a falling edge: drive, check current outputs, clock once, update model.
    task automatic cycle(input logic en, input logic filt, input logic clr,
                         input logic [31:0] p, input logic [3:0] f, input logic rdy);
        enable   = en;
        filter   = filt;
        clear    = clr;
        pc       = p;
        instr    = 32'hC0DE_0000 ^ {p[15:0], p[15:0]} ^ {28'h0, f};
        flags    = f;
        rd_ready = rdy;
        check_all();
        @(posedge clock);
        model_edge(en, filt, clr, p, instr, f, rdy);
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        ts    = '0;
        ovf[0] = 1'b0;
        ovf[1] = 1'b0;
        reset    = 1'b1;
        enable   = 1'b1;
        filter   = 1'b0;
        clear    = 1'b0;
        pc       = 32'hDEAD_BEEF;
        instr    = 32'h1234_5678;
        flags    = 4'hF;
        rd_ready = 1'b1;

        repeat (3) @(negedge clock);
        check_all();
        reset = 1'b0;

        // Timestamp: five idle edges after reset release, push on the sixth (ts = 5).
        repeat (5) cycle(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h100, 4'h0, 1'b0);
`ifdef TRACE_TIMESTAMP_EN
        chk("ts_at_5", 0, 64'(rtm[0]), 64'(5));
`endif
        chk("ts_pc", 0, 64'(rpc[0]), 64'h100);
        cycle(1'b0, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0);

        // Basic capture then FWFT drain.
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 4'b0001, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'd4, 4'b0001, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'd8, 4'b0001, 1'b0);
        chk("basic_count", 0, 64'(cnt[0]), 64'(3));
        chk("basic_head", 0, 64'(rpc[0]), 64'(0));
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1);

        // Six pushes into depth 4: stop-on-full keeps oldest, wrap keeps newest.
        cycle(1'b0, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0);
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 1'b0, 32'(4 * k), 4'b0010, 1'b0);
        chk("full_count", 0, 64'(cnt[0]), 64'(4));
        chk("full_count", 1, 64'(cnt[1]), 64'(4));
        chk("full_ovf", 0, 64'(ovfo[0]), 64'(1));
        chk("full_ovf", 1, 64'(ovfo[1]), 64'(1));
        chk("full_head", 0, 64'(rpc[0]), 64'(0));
        chk("full_head", 1, 64'(rpc[1]), 64'(8));
        repeat (5) cycle(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1);
        chk("ovf_sticky", 0, 64'(ovfo[0]), 64'(1));
        cycle(1'b0, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0);

        // Flow-change filter.
        cycle(1'b1, 1'b1, 1'b0, 32'h20, 4'b0001, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 32'h24, 4'b1000, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 32'h28, 4'b0100, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 32'h2C, 4'b0011, 1'b0);
        chk("filter_count", 0, 64'(cnt[0]), 64'(2));
        chk("filter_head", 0, 64'(rfl[0]), 64'(4'b1000));
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1);

        // Empty with push and ready: no pop, entry stored.
        cycle(1'b1, 1'b0, 1'b0, 32'h40, 4'h0, 1'b1);
        chk("empty_push_count", 0, 64'(cnt[0]), 64'(1));
        cycle(1'b0, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0);

        // Full with simultaneous push and pop, then clear overriding push.
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b0, 32'(32'h60 + 4 * k), 4'h1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h70, 4'h1, 1'b1);
        chk("pp_count", 0, 64'(cnt[0]), 64'(4));
        chk("pp_count", 1, 64'(cnt[1]), 64'(4));
        chk("pp_ovf", 0, 64'(ovfo[0]), 64'(0));
        chk("pp_ovf", 1, 64'(ovfo[1]), 64'(0));
        cycle(1'b1, 1'b0, 1'b1, 32'h74, 4'h1, 1'b1);
        chk("clr_count", 0, 64'(cnt[0]), 64'(0));
        chk("clr_valid", 1, 64'(rdv[1]), 64'(0));

        // Asynchronous reset mid-fill, sampled inside the low clock phase.
        cycle(1'b1, 1'b0, 1'b0, 32'h80, 4'h2, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h84, 4'h2, 1'b0);
        enable = 1'b0;
        #1 reset = 1'b1;
        #1;
        for (int w = 0; w < 2; w++) begin
            chk("async_count", w, 64'(cnt[w]), 64'(0));
            chk("async_valid", w, 64'(rdv[w]), 64'(0));
            chk("async_pc", w, 64'(rpc[w]), 64'(0));
            sb[w].delete();
            ovf[w] = 1'b0;
        end
        ts = '0;
        #1 reset = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 32'h90, 4'h3, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_trace_buffer.md
CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

Interface
REQ-001 Parameter ADDR_W, default 32, width of captured PC field.
REQ-002 Parameter DEPTH, default 16, entry count; power of two, >= 2.
REQ-003 Parameter WRAP, default 0; 0 = stop-on-full, 1 = overwrite-oldest.
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  capture enable; no push when low.
REQ-007 filter  in  1  0 = capture every cycle; 1 = capture only flow-change cycles.
REQ-008 clear  in  1  synchronous flush.
REQ-009 pc  in  ADDR_W  current PC of the CPU.
REQ-010 instr  in  32  current instruction word.
REQ-011 flags  in  4  {Jump, PCSrc, memWrite, regWrite}, bit 3 down to bit 0.
REQ-012 rd_valid  out  1  head entry available.
REQ-013 rd_ready  in  1  consumer accepts head entry.
REQ-014 rd_pc / rd_instr / rd_flags  out  ADDR_W / 32 / 4  head entry fields.
REQ-015 rd_time  out  16  head entry timestamp.
REQ-016 count  out  clog2(DEPTH)+1  stored entries.
REQ-017 overflow  out  1  sticky; an entry was dropped or overwritten.

Function
REQ-018 push = enable & (~filter | flags[3] | flags[2]), evaluated each rising edge.
REQ-019 A push writes {pc, instr, flags, timestamp} at wr_ptr; the entry is visible on rd_* from the next cycle (latency 1).
REQ-020 Read is first-word-fall-through: rd_* present the entry at rd_ptr whenever rd_valid = 1.
REQ-021 rd_* field outputs are forced to 0 while rd_valid = 0.
REQ-022 pop = rd_valid & rd_ready; pop advances rd_ptr by 1 on the edge.
REQ-023 rd_valid = (count != 0); rd_valid does not depend combinationally on rd_ready.
REQ-024 Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-025 Push and pop in the same cycle: both take effect and count is unchanged.
REQ-026 Empty with push and rd_ready: no pop (rd_valid = 0); push stored; count becomes 1.
REQ-027 Full, WRAP=0, push without pop: push dropped, contents unchanged, overflow set.
REQ-028 Full, WRAP=0, push with pop: both accepted, count stays DEPTH, overflow unchanged.
REQ-029 Full, WRAP=1, push without pop: oldest entry overwritten, rd_ptr advances, count stays DEPTH, overflow set.
REQ-030 Full, WRAP=1, push with pop: both accepted; no overwrite.
REQ-031 clear overrides push and pop: pointers, count and overflow go to 0 on that edge.
REQ-032 clear does not reset the timestamp counter.
REQ-033 Once set, overflow holds until reset or clear.

Reset
REQ-034 While reset is high: wr_ptr, rd_ptr, count, overflow, timestamp = 0.
REQ-035 While reset is high: rd_valid = 0, and all rd_* fields = 0.
REQ-036 Reset asserted mid-operation discards all entries immediately, independent of clock.
REQ-037 Storage array contents are not reset.

Configuration
REQ-038 Macro TRACE_TIMESTAMP_EN defined: 16-bit free-running cycle counter, +1 every edge out of reset, wraps 0xFFFF->0; value at push stored per entry and driven on rd_time.
REQ-039 TRACE_TIMESTAMP_EN undefined: no counter and no timestamp storage; rd_time is tied to 0.

Verification
REQ-040 DEPTH=4, filter=0, enable=1 for 3 cycles, pc=0,4,8, rd_ready=0 -> count=3; rd_pc=0; then rd_ready=1 -> rd_pc 4, 8, then rd_valid=0.
REQ-041 DEPTH=4, WRAP=0, 6 pushes, pc=0..20 step 4, no pops -> count=4, overflow=1; drain yields pc 0, 4, 8, 12.
REQ-042 DEPTH=4, WRAP=1, same stimulus as REQ-041 -> count=4, overflow=1; drain yields pc 8, 12, 16, 20.
REQ-043 filter=1, flags sequence 0001, 1000, 0100, 0011 -> exactly 2 entries stored, with flags 1000 then 0100.
REQ-044 Full FIFO with push and pop on the same edge -> count stays 4, overflow=0; then clear with push -> count=0, rd_valid=0.
REQ-045 TRACE_TIMESTAMP_EN defined, reset released at cycle 0, push at cycle 5 -> rd_time=5; reset pulsed mid-fill -> count=0 and rd_valid=0 before the next edge.
